// File: rtl/i2c_ram_pkg.sv
// Shared encodings and sizing for the I2C <-> RAM burst bridge.
package i2c_ram_pkg;

    localparam int RAM_DEPTH  = 32;
    localparam int RAM_ADDR_W = $clog2(RAM_DEPTH);
    localparam int MAX_BURST  = 32;

    localparam logic DIR_TX = 1'b0;
    localparam logic DIR_RX = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        TX_ADDR,
        TX_WAIT,
        TX_OFFER,
        RX_WAIT,
        FINISH
    } state_t;

    // Requested lengths above one RAM window are trimmed to a full window.
    function automatic logic [5:0] clampLen(input logic [5:0] l);
        return (l > 6'(MAX_BURST)) ? 6'(MAX_BURST) : l;
    endfunction

endpackage

// File: rtl/i2c_ram_bridge.sv
// Burst mover between the I2C byte engine and the RAM controller's I2C-side ports.
// TX streams local RAM to the transmitter; RX writes received bytes into remote RAM.
module i2c_ram_bridge
    import i2c_ram_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              dir,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [5:0]        len,
    output logic [ADDR_W-1:0] LocalRAM_RADD,
    input  logic [DATA_W-1:0] LocalRAM_DOUT,
    output logic [ADDR_W-1:0] RemoteRAM_WADD,
    output logic [DATA_W-1:0] RemoteRAM_DIN,
    output logic              RemoteRAM_W,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [5:0]        count
);

    // Handshake: a TX byte transfers on a rising edge where tx_valid & tx_ready are both high;
    // tx_data is held while tx_valid waits. An RX byte is a single-cycle rx_valid strobe, no back-pressure.

    state_t            state, nextState;
    logic [ADDR_W-1:0] addr;
    logic [5:0]        burstLen;
    logic [5:0]        startLen;
    logic [5:0]        countInc;
    logic              lastByte;
    logic              txFire;
    logic              abortHit;

    assign startLen = clampLen(len);
    assign countInc = count + 6'd1;
    assign lastByte = (countInc == burstLen);
    assign txFire   = tx_valid & tx_ready;
    assign abortHit = abort & (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        if (abortHit) begin
            nextState = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (startLen == 6'd0)  nextState = FINISH;
                        else if (dir == DIR_RX) nextState = RX_WAIT;
                        else                    nextState = TX_ADDR;
                    end
                end
                TX_ADDR:  nextState = TX_WAIT;
                TX_WAIT:  nextState = TX_OFFER;
                TX_OFFER: if (txFire) nextState = lastByte ? FINISH : TX_ADDR;
                RX_WAIT:  if (rx_valid && lastByte) nextState = FINISH;
                FINISH:   nextState = IDLE;
                default:  nextState = IDLE;
            endcase
        end
    end

    // The read address register is only loaded when a new byte is fetched, so it stays put during stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr           <= '0;
            burstLen       <= '0;
            count          <= '0;
            LocalRAM_RADD  <= '0;
            RemoteRAM_WADD <= '0;
            RemoteRAM_DIN  <= '0;
            RemoteRAM_W    <= 1'b0;
            tx_data        <= '0;
            tx_valid       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
        end else begin
            RemoteRAM_W <= 1'b0;
            busy        <= (nextState != IDLE);
            done        <= (state == FINISH) && !abort;
            error       <= abortHit;
            if (abortHit) begin
                tx_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            addr     <= base_addr;
                            burstLen <= startLen;
                            count    <= '0;
                            if (dir == DIR_TX && startLen != 6'd0) LocalRAM_RADD <= base_addr;
                        end
                    end
                    TX_WAIT: begin
                        tx_data  <= LocalRAM_DOUT;
                        tx_valid <= 1'b1;
                    end
                    TX_OFFER: begin
                        if (txFire) begin
                            tx_valid <= 1'b0;
                            count    <= countInc;
                            addr     <= addr + 1'b1;
                            if (!lastByte) LocalRAM_RADD <= addr + 1'b1;
                        end
                    end
                    RX_WAIT: begin
                        if (rx_valid) begin
                            RemoteRAM_W    <= 1'b1;
                            RemoteRAM_WADD <= addr;
                            RemoteRAM_DIN  <= rx_data;
                            addr           <= addr + 1'b1;
                            count          <= countInc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_ram_bridge.sv
// Randomized scoreboard bench for i2c_ram_bridge: a burst-level reference model queues
// expected TX bytes, remote writes and end-of-burst events; a negedge monitor consumes them.
module tb_i2c_ram_bridge;
    import i2c_ram_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       start, dir;
    logic [4:0] base_addr;
    logic [5:0] len;
    logic [4:0] LocalRAM_RADD;
    logic [7:0] LocalRAM_DOUT;
    logic [4:0] RemoteRAM_WADD;
    logic [7:0] RemoteRAM_DIN;
    logic       RemoteRAM_W;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, abort;
    logic       busy, done, error;
    logic [5:0] count;

    i2c_ram_bridge #(.ADDR_W(5), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .base_addr(base_addr), .len(len),
        .LocalRAM_RADD(LocalRAM_RADD), .LocalRAM_DOUT(LocalRAM_DOUT),
        .RemoteRAM_WADD(RemoteRAM_WADD), .RemoteRAM_DIN(RemoteRAM_DIN), .RemoteRAM_W(RemoteRAM_W),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .abort(abort),
        .busy(busy), .done(done), .error(error), .count(count)
    );

    // ---------------- clock / reset / RAM model ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] localMem [RAM_DEPTH];
    always @(posedge clk) LocalRAM_DOUT <= localMem[LocalRAM_RADD];

    // ---------------- scoreboard state ----------------
    logic [7:0]  expTxQ[$];
    logic [12:0] expWrQ[$];
    logic [7:0]  expEndQ[$];   // {error, done, count}

    int checks = 0;
    int errors = 0;
    int startCyc, firstRise, fallCyc, endCyc, lastHsEdge;
    int raddChanges = 0;
    bit gapArmed, endSeen, prevValid;
    logic [4:0] prevRadd = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int effLen(input int l);
        return (l > MAX_BURST) ? MAX_BURST : l;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_valid && tx_ready && !abort) begin
                check("tx_expected", expTxQ.size() > 0, 1);
                if (expTxQ.size() > 0) check("tx_data", tx_data, expTxQ.pop_front());
                lastHsEdge = cyc + 1;
            end
            if (tx_valid && !prevValid) begin
                if (firstRise < 0) firstRise = cyc;
                else if (gapArmed) check("tx_gap", cyc - fallCyc, 2);
            end
            if (!tx_valid && prevValid) begin
                fallCyc  = cyc;
                gapArmed = busy;
            end
            prevValid = tx_valid;
            if (RemoteRAM_W) begin
                check("wr_expected", expWrQ.size() > 0, 1);
                if (expWrQ.size() > 0) check("wr_addr_data", {RemoteRAM_WADD, RemoteRAM_DIN}, expWrQ.pop_front());
            end
            if (done || error) begin
                check("end_expected", expEndQ.size() > 0, 1);
                if (expEndQ.size() > 0) check("end_event", {error, done, count}, expEndQ.pop_front());
                check("busy_at_end", busy, 0);
                endCyc  = cyc;
                endSeen = 1;
            end
            if (LocalRAM_RADD != prevRadd) raddChanges++;
            prevRadd = LocalRAM_RADD;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulseStart(input logic d, input logic [4:0] b, input logic [5:0] l);
        @(posedge clk); #1;
        start = 1; dir = d; base_addr = b; len = l;
        startCyc = cyc; firstRise = -1; gapArmed = 0; endSeen = 0;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic waitEnd(input int expCount);
        for (int k = 0; k < 300 && !endSeen; k++) begin @(posedge clk); #1; end
        check("burst_end_seen", endSeen, 1);
        @(posedge clk); #1;
        check("count_final", count, expCount);
        check("busy_idle", busy, 0);
        check("queues_drained", expTxQ.size() + expWrQ.size() + expEndQ.size(), 0);
        expTxQ.delete(); expWrQ.delete(); expEndQ.delete();
    endtask

    task automatic txBurst(input logic [4:0] b, input logic [5:0] l, input bit holdReady,
                           input int stallByte, input int stallLen, input bit randStall, input int abortAt);
        int n, good, s;
        n = effLen(l);
        good = (abortAt >= 0 && abortAt < n) ? abortAt : n;
        for (int i = 0; i < good; i++) expTxQ.push_back(localMem[5'(b + i)]);
        if (good < n) expEndQ.push_back({1'b1, 1'b0, 6'(good)});
        else          expEndQ.push_back({1'b0, 1'b1, 6'(n)});
        tx_ready = holdReady;
        pulseStart(DIR_TX, b, l);
        if (!holdReady) begin
            for (int i = 0; i < n; i++) begin
                for (int k = 0; k < 10 && !tx_valid; k++) begin @(posedge clk); #1; end
                if (!tx_valid) begin
                    check("tx_valid_seen", tx_valid, 1);
                    break;
                end
                s = (i == stallByte) ? stallLen : (randStall ? int'($urandom_range(0, 2)) : 0);
                for (int k = 0; k < s; k++) begin
                    check("stall_data", tx_data, localMem[5'(b + i)]);
                    check("stall_radd", LocalRAM_RADD, 5'(b + i));
                    @(posedge clk); #1;
                end
                tx_ready = 1;
                if (i == abortAt) abort = 1;
                @(posedge clk); #1;
                tx_ready = 0; abort = 0;
                if (i == abortAt) break;
            end
        end
        waitEnd(good);
        tx_ready = 0;
    endtask

    task automatic rxBurst(input logic [4:0] b, input logic [5:0] l, input bit randGap,
                           input int abortAt, input bit extraStart, input bit fixedData);
        int n, good;
        logic [7:0] d;
        n = effLen(l);
        good = (abortAt >= 0 && abortAt < n) ? abortAt : n;
        if (good < n) expEndQ.push_back({1'b1, 1'b0, 6'(good)});
        else          expEndQ.push_back({1'b0, 1'b1, 6'(n)});
        pulseStart(DIR_RX, b, l);
        for (int i = 0; i < n; i++) begin
            if (randGap) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            d = fixedData ? 8'(8'hA1 + 8'h11 * i) : 8'($urandom_range(0, 255));
            rx_data = d; rx_valid = 1;
            if (i == abortAt) abort = 1;
            else expWrQ.push_back({5'(b + i), d});
            if (extraStart && i == 0) begin
                start = 1; base_addr = b + 5'd1; len = 6'd3;
            end
            @(posedge clk); #1;
            rx_valid = 0; abort = 0; start = 0;
            if (i == abortAt) break;
        end
        if (good == n) begin
            // A strobe arriving after the last byte must be ignored.
            rx_data = 8'($urandom_range(0, 255)); rx_valid = 1;
            @(posedge clk); #1;
            rx_valid = 0;
        end
        waitEnd(good);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int r, rl, ab;
        bit hr;
        logic [4:0] rb;
        rst_n = 0; start = 0; dir = 0; base_addr = '0; len = '0;
        tx_ready = 0; rx_data = '0; rx_valid = 0; abort = 0;
        for (int i = 0; i < RAM_DEPTH; i++) localMem[i] = 8'(i);
        repeat (3) @(posedge clk);
        #1;
        check("reset_ram_ports", {LocalRAM_RADD, RemoteRAM_WADD, RemoteRAM_DIN, RemoteRAM_W}, 0);
        check("reset_ctl_ports", {tx_data, tx_valid, busy, done, error, count}, 0);
        rst_n = 1;

        // TX base 0 len 3, ready held high: latency and done timing
        txBurst(5'd0, 6'd3, 1, -1, 0, 0, -1);
        check("tx_first_latency", firstRise - startCyc, 3);
        check("done_after_hs", endCyc - lastHsEdge, 1);

        // TX with a 5-cycle stall on the second byte
        txBurst(5'd0, 6'd3, 0, 1, 5, 0, -1);

        // RX wrap: 30,31,0,1
        rxBurst(5'd30, 6'd4, 0, -1, 0, 1);

        // RX abort on third strobe
        rxBurst(5'($urandom_range(0, 31)), 6'd5, 0, 2, 0, 0);

        // len 0 in both directions, then clamping of 40 to 32
        r = raddChanges;
        txBurst(5'd9, 6'd0, 1, -1, 0, 0, -1);
        check("len0_radd_quiet", raddChanges - r, 0);
        check("len0_done_latency", endCyc - startCyc, 2);
        rxBurst(5'd3, 6'd0, 0, -1, 0, 0);
        for (int i = 0; i < RAM_DEPTH; i++) localMem[i] = 8'($urandom_range(0, 255));
        txBurst(5'($urandom_range(0, 31)), 6'd40, 0, -1, 0, 1, -1);
        rxBurst(5'($urandom_range(0, 31)), 6'd40, 1, -1, 1, 0);

        // abort while idle does nothing
        @(posedge clk); #1; abort = 1;
        @(posedge clk); #1; abort = 0;
        check("idle_abort_quiet", {error, busy}, 0);

        // reset in the middle of a TX offer, then a clean burst
        tx_ready = 0;
        pulseStart(DIR_TX, 5'd7, 6'd5);
        for (int k = 0; k < 10 && !tx_valid; k++) begin @(posedge clk); #1; end
        check("pre_reset_valid", tx_valid, 1);
        #2 rst_n = 0;
        #1;
        check("midreset_ram_ports", {LocalRAM_RADD, RemoteRAM_WADD, RemoteRAM_DIN, RemoteRAM_W}, 0);
        check("midreset_ctl_ports", {tx_data, tx_valid, busy, done, error, count}, 0);
        @(posedge clk); #1;
        rst_n = 1;
        txBurst(5'd7, 6'd5, 0, -1, 0, 1, -1);

        // randomized bursts
        for (int t = 0; t < 14; t++) begin
            rb = 5'($urandom_range(0, 31));
            rl = $urandom_range(0, 40);
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, rl)) : -1;
            hr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) txBurst(rb, 6'(rl), hr, -1, 0, 1, hr ? -1 : ab);
            else                           rxBurst(rb, 6'(rl), 1, ab, 1'($urandom_range(0, 1)), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
